dac_shift_agc: RTL and testbench

Automatic shift controller for the TX DAC path. It sits directly upstream of the DAC rounding/truncation stage. It takes the wide signed TX sample stream, measures the signal headroom, and drives the left-shift `distance` that the downstream stage applies before truncating to DAC width. The delayed sample and the `distance` that applies to it leave this block on the same clock edge, so a sample is never shifted into overflow.

---
 rtl/dac_shift_agc.sv | 140 ++++++++++++++
 tb/tb_dac_shift_agc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dac_shift_agc.sv
// rtl/dac_shift_agc.sv - TX DAC automatic shift (headroom) controller
// Optional: define DAC_AGC_FAST_RELEASE_EN to release straight to the measured window headroom.
module dac_shift_agc #(
   parameter int in_width     = 27,
   parameter int out_width    = 14,
   parameter int WINDOW_LOG2  = 10,
   parameter int HOLD_WINDOWS = 8
) (
   input  logic                       clk_in,
   input  logic                       rst_n,
   input  logic signed [in_width-1:0] DATA_IN,
   input  logic                       data_valid,
   input  logic                       enable,
   input  logic [7:0]                 manual_distance,
   output logic signed [in_width-1:0] DATA_OUT,
   output logic                       DATA_OUT_valid,
   output logic [7:0]                 distance,
   output logic [1:0]                 state_out
);

   localparam int MAX_SHIFT = in_width - out_width;
   localparam logic [7:0] MAX_D  = 8'(MAX_SHIFT);
   localparam logic [7:0] HOLD_N = 8'(HOLD_WINDOWS);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_TRACK  = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                 state, state_nx;
   logic [7:0]             dist_nx;
   logic [WINDOW_LOG2-1:0] win_cnt, cnt_nx;
   logic [7:0]             win_min, min_nx;
   logic [7:0]             hold_cnt, hold_nx;

   logic [7:0] s_req;
   logic       run;
   logic [7:0] min_now;
   logic [7:0] man_cl;
   logic [7:0] hold_inc;
   logic [7:0] rel_value;
   logic       win_end;
   logic       attack;
   logic       quiet;

   // Count bits below the sign that still match it; scanning stops at MAX_SHIFT, which is the clamp.
   always_comb begin
      s_req = '0;
      run   = 1'b1;
      for (int i = in_width - 2; i >= in_width - 1 - MAX_SHIFT; i--) begin
         if (run && (DATA_IN[i] == DATA_IN[in_width-1]))
            s_req = s_req + 8'd1;
         else
            run = 1'b0;
      end
   end

   always_comb begin
      min_now = (s_req < win_min) ? s_req : win_min;
      man_cl  = (manual_distance > MAX_D) ? MAX_D : manual_distance;
      win_end = data_valid && (win_cnt == '1);
      attack  = data_valid && (s_req < distance);
      quiet   = min_now > distance;
      hold_inc = (state == ST_HOLD) ? hold_cnt + 8'd1 : 8'd1;
`ifdef DAC_AGC_FAST_RELEASE_EN
      rel_value = min_now;
`else
      rel_value = (distance >= MAX_D) ? MAX_D : distance + 8'd1;
`endif
   end

   always_comb begin
      state_nx = state;
      dist_nx  = distance;
      cnt_nx   = win_cnt;
      min_nx   = win_min;
      hold_nx  = hold_cnt;
      if (!enable || state == ST_MANUAL) begin
         state_nx = enable ? ST_TRACK : ST_MANUAL;
         dist_nx  = man_cl;
         cnt_nx   = '0;
         min_nx   = MAX_D;
         hold_nx  = '0;
      end else begin
         if (data_valid) begin
            cnt_nx = win_cnt + 1'b1;
            min_nx = win_end ? MAX_D : min_now;
         end
         // Attack takes priority over any window-end decision on the same sample.
         if (attack) begin
            dist_nx  = s_req;
            hold_nx  = '0;
            state_nx = ST_TRACK;
         end else if (win_end) begin
            if (quiet && hold_inc >= HOLD_N) begin
               dist_nx  = rel_value;
               hold_nx  = '0;
               state_nx = ST_TRACK;
            end else if (quiet) begin
               hold_nx  = hold_inc;
               state_nx = ST_HOLD;
            end else begin
               hold_nx  = '0;
               state_nx = ST_TRACK;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_MANUAL;
         distance <= '0;
         win_cnt  <= '0;
         win_min  <= MAX_D;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         distance <= dist_nx;
         win_cnt  <= cnt_nx;
         win_min  <= min_nx;
         hold_cnt <= hold_nx;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         DATA_OUT       <= '0;
         DATA_OUT_valid <= 1'b0;
      end else begin
         DATA_OUT_valid <= data_valid;
         if (data_valid)
            DATA_OUT <= DATA_IN;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_dac_shift_agc.sv
// tb/tb_dac_shift_agc.sv - self-checking bench for dac_shift_agc
module tb_dac_shift_agc;
   localparam int W = 27;

   logic                clk_in = 1'b0;
   logic                rst_n;
   logic signed [W-1:0] DATA_IN;
   logic                data_valid;
   logic                enable;
   logic [7:0]          manual_distance;
   logic signed [W-1:0] DATA_OUT;
   logic                DATA_OUT_valid;
   logic [7:0]          distance;
   logic [1:0]          state_out;

   always #5 clk_in = ~clk_in;

   dac_shift_agc #(
      .in_width(W), .out_width(14), .WINDOW_LOG2(4), .HOLD_WINDOWS(2)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .DATA_IN(DATA_IN), .data_valid(data_valid),
      .enable(enable), .manual_distance(manual_distance), .DATA_OUT(DATA_OUT),
      .DATA_OUT_valid(DATA_OUT_valid), .distance(distance), .state_out(state_out)
   );

   int tests = 0;
   int fails = 0;
   logic signed [W-1:0] sb_q[$];
   logic signed [W-1:0] last_out = '0;

   typedef struct {
      logic                en;
      logic [7:0]          man;
      logic                v;
      logic signed [W-1:0] d;
      int                  exp_dist;
      int                  exp_state;
   } vec_t;
   vec_t vt[9];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      logic signed [W-1:0] e;
      @(posedge clk_in);
      #1;
      if (DATA_OUT_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_out", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("data_out", int'(DATA_OUT), int'(e));
            last_out = e;
         end
      end else begin
         check("data_hold", int'(DATA_OUT), int'(last_out));
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] man, input logic v,
                        input logic signed [W-1:0] d);
      enable          = en;
      manual_distance = man;
      data_valid      = v;
      DATA_IN         = d;
      if (v) sb_q.push_back(d);
      tick();
      check("out_valid", int'(DATA_OUT_valid), int'(v));
   endtask

   task automatic run_samples(input int count, input logic [7:0] man);
      for (int k = 0; k < count; k++)
         drive(1'b1, man, 1'b1, (k % 2 == 0) ? 27'sd1 : -27'sd1);
   endtask

   function automatic int exp_d(input int n);
      int d;
`ifdef DAC_AGC_FAST_RELEASE_EN
      d = (n >= 32) ? 13 : 5;
`else
      d = 5 + n / 32;
      if (d > 13) d = 13;
`endif
      return d;
   endfunction

   function automatic int exp_s(input int n);
`ifdef DAC_AGC_FAST_RELEASE_EN
      return (n >= 16 && n < 32) ? 2 : 1;
`else
      return (exp_d(n) < 13 && (n % 32) >= 16) ? 2 : 1;
`endif
   endfunction

   initial begin
      rst_n = 1'b0; enable = 1'b0; manual_distance = 8'd0; data_valid = 1'b0; DATA_IN = '0;
      vt[0] = '{1'b0, 8'd20, 1'b0, 27'sd0,          13, 0};
      vt[1] = '{1'b0, 8'd4,  1'b0, 27'sd0,           4, 0};
      vt[2] = '{1'b0, 8'd13, 1'b0, 27'sd0,          13, 0};
      vt[3] = '{1'b1, 8'd13, 1'b0, 27'sd0,          13, 1};
      vt[4] = '{1'b1, 8'd13, 1'b1, 27'sd1048576,     5, 1};
      vt[5] = '{1'b1, 8'd13, 1'b1, -27'sd67108864,   0, 1};
      vt[6] = '{1'b1, 8'd13, 1'b1, 27'sd0,           0, 1};
      vt[7] = '{1'b0, 8'd5,  1'b0, 27'sd0,           5, 0};
      vt[8] = '{1'b1, 8'd5,  1'b0, 27'sd0,           5, 1};

      #12;
      check("rst_data_out", int'(DATA_OUT), 0);
      check("rst_out_valid", int'(DATA_OUT_valid), 0);
      check("rst_distance", int'(distance), 0);
      check("rst_state", int'(state_out), 0);
      @(negedge clk_in);
      rst_n = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].en, vt[i].man, vt[i].v, vt[i].d);
         check($sformatf("vec%0d_distance", i), int'(distance), vt[i].exp_dist);
         check($sformatf("vec%0d_state", i), int'(state_out), vt[i].exp_state);
      end

      // Release staircase from distance 5 with quiet +-1 input, idle gaps interleaved.
      for (int n = 1; n <= 288; n++) begin
         drive(1'b1, 8'd5, 1'b1, (n % 2 == 1) ? 27'sd1 : -27'sd1);
         check($sformatf("rel_dist_n%0d", n), int'(distance), exp_d(n));
         check($sformatf("rel_state_n%0d", n), int'(state_out), exp_s(n));
         if (n % 7 == 0) begin
            drive(1'b1, 8'd5, 1'b0, 27'sd0);
            check("idle_dist", int'(distance), exp_d(n));
            check("idle_state", int'(state_out), exp_s(n));
         end
      end

      // Attack landing on the window end of a qualifying HOLD window.
      drive(1'b0, 8'd5, 1'b0, 27'sd0);
      drive(1'b1, 8'd5, 1'b0, 27'sd0);
      run_samples(16, 8'd5);
      check("hold_entered", int'(state_out), 2);
      run_samples(15, 8'd5);
      drive(1'b1, 8'd5, 1'b1, 27'sd4194304);
      check("atk_we_dist", int'(distance), 3);
      check("atk_we_state", int'(state_out), 1);
      run_samples(16, 8'd5);
      check("post_atk_hold_state", int'(state_out), 2);
      check("post_atk_hold_dist", int'(distance), 3);
      run_samples(16, 8'd5);
`ifdef DAC_AGC_FAST_RELEASE_EN
      check("post_atk_release", int'(distance), 13);
`else
      check("post_atk_release", int'(distance), 4);
`endif
      check("post_atk_rel_state", int'(state_out), 1);

      // Asynchronous reset in HOLD with distance 7, mid-window.
      drive(1'b0, 8'd7, 1'b0, 27'sd0);
      drive(1'b1, 8'd7, 1'b0, 27'sd0);
      run_samples(21, 8'd7);
      check("pre_rst_state", int'(state_out), 2);
      check("pre_rst_dist", int'(distance), 7);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dist", int'(distance), 0);
      check("async_rst_data", int'(DATA_OUT), 0);
      check("async_rst_state", int'(state_out), 0);
      check("async_rst_valid", int'(DATA_OUT_valid), 0);
      sb_q.delete();
      last_out = '0;
      enable = 1'b1;
      data_valid = 1'b0;
      @(negedge clk_in);
      rst_n = 1'b1;
      tick();
      check("post_rst_state", int'(state_out), 1);
      check("post_rst_dist", int'(distance), 7);
      check("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
